// File: rtl/router_pkg.sv
// Shared types and header layout for the router egress arbiter.
package router_pkg;
  localparam int DW           = 8;
  localparam int NCH          = 3;
  localparam int ADDR_LSB     = 0;
  localparam int ADDR_W       = 2;
  localparam int LEN_LSB      = 2;
  localparam int LEN_W        = 6;
  localparam int PKT_OVERHEAD = 2;
  localparam int CNT_W        = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DW-1:0] hdr);
    return hdr[LEN_LSB +: LEN_W];
  endfunction
endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, one-hot out.
// Zero latency; no backpressure (pure function of req/ptr).
module router_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          found
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arb.sv
// Packet-granular round-robin egress scheduler over NCH output FIFOs; read_enb -> pkt_vld is 1 cycle.
// Reads stall on egress_ready low or empty FIFO; ROUTER_ARB_TIMEOUT_EN adds a mid-packet starvation abort.
module router_out_arb
  import router_pkg::*;
#(
  parameter int NCH         = router_pkg::NCH,
  parameter int DW          = router_pkg::DW,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    vld_out,
  input  logic [NCH*DW-1:0] fifo_data,
  input  logic              egress_ready,
  output logic [NCH-1:0]    read_enb,
  output logic [DW-1:0]     pkt_data,
  output logic              pkt_vld,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [NCH-1:0]    grant,
  output logic              arb_busy,
  output logic              err_abort
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_e       state_q, state_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] recvd_q, recvd_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             hdr_cap_q, hdr_cap_d;
  logic             inflight_q, inflight_d;

  logic [NCH-1:0]   pick_gnt;
  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic             active, g_vld, rd_ok, hdr_byte, last_byte, abort;
  logic [DW-1:0]    cur_byte;
  logic [CNT_W-1:0] limit;

  router_rr_pick #(.N(NCH), .PW(PW)) u_pick (
    .req   (vld_out),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    cur_byte = '0;
    for (int k = 0; k < NCH; k++) begin
      if (pick_gnt[k]) pick_idx = PW'(k);
      if (grant_q[k])  cur_byte = cur_byte | fifo_data[k*DW +: DW];
    end
  end

  // Until the header is seen only header+parity may be fetched, so LEN=0 never over-reads.
  assign limit     = hdr_cap_q ? (CNT_W'(len_q) + CNT_W'(PKT_OVERHEAD)) : CNT_W'(PKT_OVERHEAD);
  assign active    = (state_q == HDR) || (state_q == BODY);
  assign g_vld     = |(vld_out & grant_q);
  assign rd_ok     = active && g_vld && egress_ready && (issued_q < limit);
  assign hdr_byte  = inflight_q && (recvd_q == '0);
  assign last_byte = inflight_q && (recvd_q != '0) && (recvd_q == CNT_W'(len_q) + CNT_W'(1));

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] starve_q, starve_d;
  logic          starving;

  always_comb begin
    starving = active && !g_vld && !inflight_q;
    starve_d = starve_q;
    if (!active || rd_ok) starve_d = '0;
    else if (starving)    starve_d = starve_q + TW'(1);
    abort = starving && (starve_q == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  // No starvation timeout without ROUTER_ARB_TIMEOUT_EN; abort never fires.
  assign abort = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      issued_q   <= '0;
      recvd_q    <= '0;
      len_q      <= '0;
      hdr_cap_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      issued_q   <= issued_d;
      recvd_q    <= recvd_d;
      len_q      <= len_d;
      hdr_cap_q  <= hdr_cap_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = HDR;
      HDR:     if (abort) state_d = GAP;
               else if (hdr_byte) state_d = BODY;
      BODY:    if (abort || last_byte) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    issued_d   = issued_q + CNT_W'(rd_ok);
    recvd_d    = recvd_q + CNT_W'(inflight_q);
    len_d      = len_q;
    hdr_cap_d  = hdr_cap_q;
    inflight_d = rd_ok;
    if (hdr_byte) begin
      len_d     = hdr_len(cur_byte);
      hdr_cap_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        issued_d  = '0;
        recvd_d   = '0;
        len_d     = '0;
        hdr_cap_d = 1'b0;
        if (pick_found) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
        end
      end
      HDR, BODY: begin
        // Ownership ends on the way into GAP; the channel after the owner gets first pick next.
        if (state_d == GAP) begin
          grant_d = '0;
          ptr_d   = (gidx_q == PW'(NCH - 1)) ? '0 : gidx_q + PW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    read_enb  = rd_ok ? grant_q : '0;
    pkt_vld   = inflight_q;
    pkt_data  = inflight_q ? cur_byte : '0;
    pkt_sop   = hdr_byte;
    pkt_eop   = last_byte;
    grant     = grant_q;
    arb_busy  = (state_q != IDLE);
    err_abort = abort;
  end

endmodule
